// File: rtl/data_memory_if.sv
// Request/response bus between the cpu memory stage and the data RAM.
interface data_memory_if;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic        mem_valid;
    logic [31:0] mem_read_data;
    logic        busy;
    logic [31:0] stall_cycles;

    modport master (
        output mem_addr, mem_read, mem_write, mem_write_data,
        input  mem_valid, mem_read_data, busy, stall_cycles
    );

    modport slave (
        input  mem_addr, mem_read, mem_write, mem_write_data,
        output mem_valid, mem_read_data, busy, stall_cycles
    );
endinterface

// File: rtl/data_memory.sv
// Word-addressed data RAM with programmable wait states and a stall-cycle counter.
module data_memory #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned LATENCY  = 2,
    parameter              MEM_INIT = ""
) (
    input  logic          clk,
    input  logic          rst,
    data_memory_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] w_idx;
    logic          w_req;
    logic          w_valid;
    logic [31:0]   r_stall_cycles;
    logic          w_unused_addr;

    // Parameter legality is checked at elaboration.
    if (LATENCY > 15) begin : g_bad_latency
        $error("data_memory: LATENCY %0d exceeds 15", LATENCY);
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("data_memory: DEPTH %0d is not a power of two >= 2", DEPTH);
    end
    if (MEM_INIT != "") begin : g_preload_note
        $info("data_memory: preload image %s is applied by the RAM load flow", MEM_INIT);
    end

    // Upper address bits alias and byte offset is ignored.
    assign w_idx         = bus.mem_addr[AW+1:2];
    assign w_unused_addr = ^{bus.mem_addr[31:AW+2], bus.mem_addr[1:0]};
    assign w_req         = bus.mem_read | bus.mem_write;

    assign bus.mem_valid    = w_valid;
    assign bus.stall_cycles = r_stall_cycles;

    // Count cycles the cpu is held with a request outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_req && !w_valid) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    if (LATENCY == 0) begin : g_comb
        assign w_valid           = 1'b1;
        assign bus.busy          = 1'b0;
        assign bus.mem_read_data = r_mem[w_idx];

        // Zero-wait store lands on the edge closing the request cycle.
        always_ff @(posedge clk) begin
            if (bus.mem_write) begin
                r_mem[w_idx] <= bus.mem_write_data;
            end
        end
    end else begin : g_fsm
        typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

        state_t        r_state, w_state_nxt;
        logic [CW-1:0] r_cnt, w_cnt_nxt;
        logic [AW-1:0] r_idx;
        logic          r_write;
        logic [31:0]   r_wdata;
        logic [31:0]   r_rdata;
        logic          w_accept;
        logic          w_enter_done;
        logic [AW-1:0] w_do_idx;
        logic          w_do_write;
        logic [31:0]   w_do_wdata;

        assign bus.busy          = (r_state != S_IDLE);
        assign bus.mem_read_data = r_rdata;

        // State and wait counter registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // Next state, handshake and accept decode.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_valid     = 1'b0;
            w_accept    = 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    w_valid = ~w_req;
                    if (w_req) begin
                        w_accept    = 1'b1;
                        w_cnt_nxt   = CW'(LATENCY - 1);
                        w_state_nxt = (LATENCY == 1) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The edge that brings the count to zero leaves WAIT.
                    w_cnt_nxt = r_cnt - CW'(1);
                    if (r_cnt <= CW'(1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    w_valid     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        // With LATENCY==1 DONE is entered straight from the accept cycle.
        assign w_do_idx     = w_accept ? w_idx              : r_idx;
        assign w_do_write   = w_accept ? bus.mem_write      : r_write;
        assign w_do_wdata   = w_accept ? bus.mem_write_data : r_wdata;
        assign w_enter_done = ~rst & (w_state_nxt == S_DONE);

        // Capture the request fields at accept.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_idx   <= '0;
                r_write <= 1'b0;
                r_wdata <= '0;
            end else if (w_accept) begin
                r_idx   <= w_idx;
                r_write <= bus.mem_write;
                r_wdata <= bus.mem_write_data;
            end
        end

        // Load data is the pre-store word, updated only on DONE entry.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rdata <= '0;
            end else if (w_enter_done) begin
                r_rdata <= r_mem[w_do_idx];
            end
        end

        // Store commits on DONE entry; a reset before then drops it.
        always_ff @(posedge clk) begin
            if (w_enter_done && w_do_write) begin
                r_mem[w_do_idx] <= w_do_wdata;
            end
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: four latency variants against a transaction-level model.
module tb_data_memory;
    localparam int          NI    = 4;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned LATS [NI] = '{2, 4, 0, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]        t_rst;
    logic [NI-1:0]        t_rd;
    logic [NI-1:0]        t_wr;
    logic [NI-1:0][31:0]  t_addr;
    logic [NI-1:0][31:0]  t_wdata;
    logic [NI-1:0]        o_valid;
    logic [NI-1:0]        o_busy;
    logic [NI-1:0][31:0]  o_rdata;
    logic [NI-1:0][31:0]  o_stall;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        data_memory_if bus ();
        assign bus.mem_addr       = t_addr[g];
        assign bus.mem_read       = t_rd[g];
        assign bus.mem_write      = t_wr[g];
        assign bus.mem_write_data = t_wdata[g];
        assign o_valid[g]         = bus.mem_valid;
        assign o_busy[g]          = bus.busy;
        assign o_rdata[g]         = bus.mem_read_data;
        assign o_stall[g]         = bus.stall_cycles;

        data_memory #(
            .DEPTH    (DEPTH),
            .LATENCY  (LATS[g]),
            .MEM_INIT ("")
        ) u_dut (
            .clk (clk),
            .rst (t_rst[g]),
            .bus (bus)
        );
    end

    function automatic void chk(input string nm, input int n, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [lat=%0d] t=%0t: got %h, want %h", nm, LATS[n], $time, act, exp);
        end
    endfunction

    // Reference model: each accepted access completes exactly LATENCY cycles later.
    logic [31:0] m_mem    [NI][DEPTH];
    bit          m_known  [NI][DEPTH];
    bit   [31:0] m_rd     [NI];
    bit          m_rd_ok  [NI];
    bit   [31:0] m_stall  [NI];
    bit          pend     [NI];
    int          age      [NI];
    int          p_idx    [NI];
    bit          p_wr     [NI];
    bit   [31:0] p_wd     [NI];
    logic [31:0] p_old    [NI];
    bit          p_old_ok [NI];

    always @(negedge clk) begin : chk_proc
        int          lat;
        int          widx;
        bit          req, acc, e_valid, e_busy, e_rd_ok;
        logic [31:0] e_rd;
        for (int n = 0; n < NI; n++) begin
            lat  = int'(LATS[n]);
            req  = t_rd[n] | t_wr[n];
            widx = int'((t_addr[n] >> 2) % DEPTH);
            acc  = 1'b0;
            if (lat == 0) begin
                e_valid = 1'b1;
                e_busy  = 1'b0;
                e_rd    = m_mem[n][widx];
                e_rd_ok = m_known[n][widx];
            end else begin
                if (pend[n]) begin
                    e_busy  = 1'b1;
                    e_valid = (age[n] == lat);
                    if (e_valid) begin
                        m_rd[n]    = p_old[n];
                        m_rd_ok[n] = p_old_ok[n];
                        if (p_wr[n]) begin
                            m_mem[n][p_idx[n]]   = p_wd[n];
                            m_known[n][p_idx[n]] = 1'b1;
                        end
                    end
                end else begin
                    e_busy  = 1'b0;
                    e_valid = ~req;
                    acc     = req;
                end
                e_rd    = m_rd[n];
                e_rd_ok = m_rd_ok[n];
            end

            if (chk_en) begin
                chk("mem_valid", n, 32'(o_valid[n]), 32'(e_valid));
                chk("busy", n, 32'(o_busy[n]), 32'(e_busy));
                chk("stall_cycles", n, o_stall[n], m_stall[n]);
                if (e_rd_ok) chk("mem_read_data", n, o_rdata[n], e_rd);
            end

            if (req && !e_valid) m_stall[n] = m_stall[n] + 32'd1;
            if (pend[n]) begin
                if (age[n] == lat) pend[n] = 1'b0;
                else               age[n]  = age[n] + 1;
            end
            if (acc) begin
                pend[n]     = 1'b1;
                age[n]      = 1;
                p_idx[n]    = widx;
                p_wr[n]     = t_wr[n];
                p_wd[n]     = t_wdata[n];
                p_old[n]    = m_mem[n][widx];
                p_old_ok[n] = m_known[n][widx];
            end
            if (lat == 0 && t_wr[n]) begin
                m_mem[n][widx]   = t_wdata[n];
                m_known[n][widx] = 1'b1;
            end
            if (t_rst[n]) begin
                pend[n]    = 1'b0;
                m_stall[n] = '0;
                m_rd[n]    = '0;
                m_rd_ok[n] = 1'b1;
            end
        end
    end

    // One cpu access held for LATENCY+1 cycles; optional reset in hold cycle rst_at.
    task automatic xact(input int n, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit garble, input int rst_at,
                        output logic [15:0] vpat, output logic [31:0] rdat,
                        output logic [31:0] stl);
        int lat;
        lat  = int'(LATS[n]);
        vpat = '0;
        rdat = '0;
        stl  = '0;
        t_addr[n]  = a;
        t_wdata[n] = d;
        t_rd[n]    = r;
        t_wr[n]    = w;
        for (int i = 0; i <= lat; i++) begin
            if (i == rst_at) t_rst[n] = 1'b1;
            @(negedge clk);
            vpat[i] = o_valid[n];
            rdat    = o_rdata[n];
            stl     = o_stall[n];
            @(posedge clk);
            #1;
            if (i == rst_at) begin
                t_rst[n] = 1'b0;
                break;
            end
            if (garble) begin
                t_addr[n]  = $urandom;
                t_wdata[n] = $urandom;
            end
        end
        t_rd[n] = 1'b0;
        t_wr[n] = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] vp;
        logic [31:0] rd, st;
        t_rst   = '1;
        t_rd    = '0;
        t_wr    = '0;
        t_addr  = '0;
        t_wdata = '0;
        repeat (2) step();
        t_rst  = '0;
        chk_en = 1'b1;

        @(negedge clk);
        for (int n = 0; n < NI; n++) begin
            chk("reset read_data", n, o_rdata[n], 32'h0);
            chk("reset stall", n, o_stall[n], 32'h0);
            chk("reset busy", n, 32'(o_busy[n]), 32'h0);
        end
        step();

        // T1 (lat 2)
        xact(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, -1, vp, rd, st);
        chk("T1 store valid seq", 0, 32'(vp), 32'h4);
        xact(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, -1, vp, rd, st);
        chk("T1 load valid seq", 0, 32'(vp), 32'h4);
        chk("T1 load data", 0, rd, 32'hDEADBEEF);
        chk("T1 stall count", 0, st, 32'd4);
        // T2
        repeat (5) begin
            @(negedge clk);
            chk("T2 idle valid", 0, 32'(o_valid[0]), 32'h1);
            chk("T2 idle busy", 0, 32'(o_busy[0]), 32'h0);
            chk("T2 idle stall", 0, o_stall[0], 32'd4);
            step();
        end
        // T3
        xact(0, 1'b0, 1'b1, 32'h404, 32'hA5A5A5A5, 1'b0, -1, vp, rd, st);
        xact(0, 1'b1, 1'b0, 32'h004, 32'h0, 1'b0, -1, vp, rd, st);
        chk("T3 alias load", 0, rd, 32'hA5A5A5A5);
        xact(0, 1'b1, 1'b0, 32'h007, 32'h0, 1'b0, -1, vp, rd, st);
        chk("T3 low bits ignored", 0, rd, 32'hA5A5A5A5);
        // T4
        xact(0, 1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0, -1, vp, rd, st);
        xact(0, 1'b1, 1'b1, 32'h20, 32'h22222222, 1'b0, -1, vp, rd, st);
        chk("T4 rmw old word", 0, rd, 32'h11111111);
        xact(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, -1, vp, rd, st);
        chk("T4 new word", 0, rd, 32'h22222222);

        // T5 (lat 4): reset in the 2nd WAIT cycle discards the store
        xact(1, 1'b0, 1'b1, 32'h30, 32'h99, 1'b0, -1, vp, rd, st);
        chk("T5 store valid seq", 1, 32'(vp), 32'h10);
        xact(1, 1'b0, 1'b1, 32'h30, 32'h55, 1'b0, 2, vp, rd, st);
        @(negedge clk);
        chk("T5 busy after rst", 1, 32'(o_busy[1]), 32'h0);
        chk("T5 valid after rst", 1, 32'(o_valid[1]), 32'h1);
        chk("T5 stall after rst", 1, o_stall[1], 32'h0);
        step();
        xact(1, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, -1, vp, rd, st);
        chk("T5 store discarded", 1, rd, 32'h99);

        // T6 (lat 0)
        xact(2, 1'b0, 1'b1, 32'h8, 32'h7, 1'b0, -1, vp, rd, st);
        chk("T6 store valid", 2, 32'(vp), 32'h1);
        xact(2, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, -1, vp, rd, st);
        chk("T6 load valid", 2, 32'(vp), 32'h1);
        chk("T6 load data", 2, rd, 32'h7);
        chk("T6 stall", 2, st, 32'h0);

        // Single wait state (lat 1)
        xact(3, 1'b0, 1'b1, 32'h40, 32'h12345678, 1'b0, -1, vp, rd, st);
        chk("L1 store valid seq", 3, 32'(vp), 32'h2);
        xact(3, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, -1, vp, rd, st);
        chk("L1 load data", 3, rd, 32'h12345678);
        chk("L1 stall", 3, st, 32'd2);

        // Random traffic per variant, with field changes while busy and rare resets
        for (int n = 0; n < NI; n++) begin
            for (int k = 0; k < 150; k++) begin
                int          op;
                int          rst_at;
                logic [31:0] a;
                op = int'($urandom_range(0, 5));
                if (op == 0) begin
                    repeat ($urandom_range(1, 3)) step();
                end else begin
                    a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2)
                        | ($urandom & 32'h3);
                    rst_at = -1;
                    if (LATS[n] > 0 && $urandom_range(0, 24) == 0)
                        rst_at = int'($urandom_range(0, LATS[n]));
                    xact(n, (op == 1 || op == 2 || op == 5), (op >= 3), a, $urandom,
                         1'($urandom_range(0, 1)), rst_at, vp, rd, st);
                end
            end
        end

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
